fpu_cmp_operand_stage: RTL and testbench
========================================

// Module: fpu_cmp_operand_stage
// PURPOSE
//  Two-stage pipelined operand-format stage directly upstream of the FPU compare unit.
//  - Takes Rs/Rt FPR values in binary64, binary32 or binary16 and widens both to binary64.
//  - Flushes denormals to signed zero.
//  - Canonicalises NaNs so the compare's NaN test (exp==7FF, frac[51:48]!=0) is always exact.
//  - Delivers opCmd/regIdIxt aligned with the converted operands; honours pipeline hold and flush.
// PARAMETERS
//  FMT_LSB   6   bit position of the 2-bit format field in regIdIxt (fmt = regIdIxt[FMT_LSB+1:FMT_LSB])
//  QNAN_FRA  52'h8_0000_0000_0000   canonical NaN fraction
// PORTS
//  clock      in   1   core clock; all state updates on posedge
//  reset      in   1   synchronous, active-low; state cleared on a posedge where reset==0
//  exHold     in   1   pipeline stall; 1 = freeze both stages
//  exFlush    in   1   pipeline flush; 1 = kill all in-flight entries
//  inValid    in   1   input operation present this cycle
//  opCmd      in   8   command opcode
//  regIdIxt   in   8   opcode extension; [5:0] compare op, fmt field per FMT_LSB
//  regValRs   in   64  Rs raw value (binary32 in [31:0], binary16 in [15:0])
//  regValRt   in   64  Rt raw value, same packing
//  outValid   out  1   converted operation valid
//  outOpCmd   out  8   opCmd delayed 2 stages
//  outIdIxt   out  8   regIdIxt delayed 2 stages, fmt field forced to 00
//  outValRs   out  64  Rs as binary64
//  outValRt   out  64  Rt as binary64
// BEHAVIOUR
//  Reset: all S1/S2 registers 0; outValid=0, outOpCmd=0, outIdIxt=0, outValRs=0, outValRt=0.
//  Pipeline: S1 registers raw inputs + fmt + valid; S2 registers converted result.
//  Latency: exactly 2 non-held cycles from input to output; throughput 1 op/cycle.
//  Per-edge priority: reset > exFlush > exHold > advance.
//  - exFlush=1: S1.valid and S2.valid cleared; data regs may keep stale values; input dropped.
//  - exHold=1 (no flush): all S1/S2 regs keep value; input ignored (upstream also holds).
//  - advance: S1 <= inputs (S1.valid <= inValid); S2 <= convert(S1).
//  - S2.valid <= S1.valid on advance.
//  Invalid entries still propagate data; outputs are don't-care when outValid=0.
//  Bubbles (inValid=0) pass through as outValid=0.
//  Conversion, identical for Rs and Rt:
//  - fmt=00 binary64: pass through.
//  - fmt=11 reserved: treated as binary64.
//  - fmt=01 binary32, s=v[31], e=v[30:23], f=v[22:0]:
//     e==0        -> {s,63'b0} (flush to zero, denormals included)
//     e==FF,f==0  -> {s,11'h7FF,52'b0} (infinity)
//     e==FF,f!=0  -> NaN
//     else        -> {s, e+11'd896, f, 29'b0}
//  - fmt=10 binary16, s=v[15], e=v[14:10], f=v[9:0]:
//     e==0        -> {s,63'b0}
//     e==1F,f==0  -> infinity
//     e==1F,f!=0  -> NaN
//     else        -> {s, e+11'd1008, f, 42'b0}
//  - NaN rule, all formats including 00: if result exp==7FF and frac!=0, output {s,11'h7FF,QNAN_FRA}.
//  - Exponent adds are 11-bit; the bias deltas cannot overflow.
//  - binary64 denormals (exp==0, frac!=0) -> {s,63'b0}.
//  - Upper bits of regValRs/regValRt above the format width are ignored.
//  Flush with hold asserted: flush wins; the valids clear and the data regs stay held.
//  Reset mid-operation: in-flight entries lost; outValid=0 from the first edge with reset==0.
// TESTING
//  1. fmt=01, Rs=0x3F800000, Rt=0xC0000000 -> 2 cycles later
//     outValRs=0x3FF0000000000000, outValRt=0xC000000000000000, outValid=1.
//  2. fmt=10, Rs=0x3C00, Rt=0x7C00 -> outValRs=0x3FF0000000000000, outValRt=0x7FF0000000000000.
//  3. NaN canon:
//     fmt=00 Rs=0x7FF0000000000001 -> outValRs=0x7FF8000000000000;
//     fmt=01 Rt=0xFF800001 -> 0xFFF8000000000000.
//  4. FTZ: fmt=01 Rs=0x80000001 -> outValRs=0x8000000000000000;
//     fmt=00 Rt=0x0000000000000001 -> 0.
//  5. Stream A,B,C with exHold=1 for 3 cycles after B enters S1 -> outputs frozen;
//     A, B, C emerge in order with no loss or duplication.
//  6. exFlush with A in S2 and B in S1 -> next cycle outValid=0 for 2 cycles;
//     reset=0 mid-stream -> all outputs 0 next edge.

Source files
------------

// File: rtl/fpu_cmp_operand_stage.sv
// Two-stage operand-format stage ahead of the FPU compare: widens binary32/binary16
// operands to binary64, flushes denormals to signed zero and canonicalises NaNs.
module fpu_cmp_operand_stage #(
  parameter int          FMT_LSB  = 6,
  parameter logic [51:0] QNAN_FRA = 52'h8_0000_0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exHold,
  input  logic        exFlush,
  input  logic        inValid,
  input  logic [7:0]  opCmd,
  input  logic [7:0]  regIdIxt,
  input  logic [63:0] regValRs,
  input  logic [63:0] regValRt,
  output logic        outValid,
  output logic [7:0]  outOpCmd,
  output logic [7:0]  outIdIxt,
  output logic [63:0] outValRs,
  output logic [63:0] outValRt
);

  localparam logic [7:0] FMT_MASK = 8'(3) << FMT_LSB;

  // Any all-ones exponent with a nonzero fraction becomes the single quiet NaN
  // pattern, so the compare's reduced NaN test never misses a signalling NaN.
  function automatic logic [63:0] canon_nan(input logic [63:0] r);
    if (r[62:52] == 11'h7FF && r[51:0] != 52'b0)
      canon_nan = {r[63], 11'h7FF, QNAN_FRA};
    else
      canon_nan = r;
  endfunction

  function automatic logic [63:0] widen(input logic [63:0] v, input logic [1:0] fmt);
    logic [63:0] r;
    r = v;
    case (fmt)
      2'b01: begin
        if (v[30:23] == 8'h00)
          r = {v[31], 63'b0};
        else if (v[30:23] == 8'hFF)
          r = {v[31], 11'h7FF, v[22:0], 29'b0};
        else
          r = {v[31], {3'b000, v[30:23]} + 11'd896, v[22:0], 29'b0};
      end
      2'b10: begin
        if (v[14:10] == 5'h00)
          r = {v[15], 63'b0};
        else if (v[14:10] == 5'h1F)
          r = {v[15], 11'h7FF, v[9:0], 42'b0};
        else
          r = {v[15], {6'b000000, v[14:10]} + 11'd1008, v[9:0], 42'b0};
      end
      default: begin
        // binary64 and the reserved encoding: pass through, denormals flushed
        if (v[62:52] == 11'h000)
          r = {v[63], 63'b0};
      end
    endcase
    widen = canon_nan(r);
  endfunction

  logic        vld_p1, vld_p2;
  logic [7:0]  cmd_p1, cmd_p2;
  logic [7:0]  ixt_p1, ixt_p2;
  logic [63:0] rs_p1, rs_p2;
  logic [63:0] rt_p1, rt_p2;
  logic [1:0]  fmt_p1;

  assign fmt_p1 = ixt_p1[FMT_LSB+1 -: 2];

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      cmd_p1 <= '0;
      ixt_p1 <= '0;
      rs_p1  <= '0;
      rt_p1  <= '0;
      vld_p2 <= 1'b0;
      cmd_p2 <= '0;
      ixt_p2 <= '0;
      rs_p2  <= '0;
      rt_p2  <= '0;
    end else if (exFlush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (!exHold) begin
      // Stage 1: capture raw operands and command
      vld_p1 <= inValid;
      cmd_p1 <= opCmd;
      ixt_p1 <= regIdIxt;
      rs_p1  <= regValRs;
      rt_p1  <= regValRt;
      // Stage 2: converted binary64 operands, format field cleared
      vld_p2 <= vld_p1;
      cmd_p2 <= cmd_p1;
      ixt_p2 <= ixt_p1 & ~FMT_MASK;
      rs_p2  <= widen(rs_p1, fmt_p1);
      rt_p2  <= widen(rt_p1, fmt_p1);
    end
  end

  assign outValid = vld_p2;
  assign outOpCmd = cmd_p2;
  assign outIdIxt = ixt_p2;
  assign outValRs = rs_p2;
  assign outValRt = rt_p2;

endmodule

// File: tb/tb_fpu_cmp_operand_stage.sv
// Directed-vector bench for fpu_cmp_operand_stage with hand-computed binary64 results.
module tb_fpu_cmp_operand_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        exHold;
  logic        exFlush;
  logic        inValid;
  logic [7:0]  opCmd;
  logic [7:0]  regIdIxt;
  logic [63:0] regValRs;
  logic [63:0] regValRt;
  logic        outValid;
  logic [7:0]  outOpCmd;
  logic [7:0]  outIdIxt;
  logic [63:0] outValRs;
  logic [63:0] outValRt;

  int n_assert = 0;
  int n_fail   = 0;

  fpu_cmp_operand_stage dut (
    .clock    (clock),
    .reset    (reset),
    .exHold   (exHold),
    .exFlush  (exFlush),
    .inValid  (inValid),
    .opCmd    (opCmd),
    .regIdIxt (regIdIxt),
    .regValRs (regValRs),
    .regValRt (regValRt),
    .outValid (outValid),
    .outOpCmd (outOpCmd),
    .outIdIxt (outIdIxt),
    .outValRs (outValRs),
    .outValRt (outValRt)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] fmt, input logic [7:0] cmd,
                       input logic [63:0] rs, input logic [63:0] rt);
    inValid  = v;
    opCmd    = cmd;
    regIdIxt = {fmt, 6'h15};
    regValRs = rs;
    regValRt = rt;
  endtask

  // Issue one op, follow it with a bubble, and check it two edges later.
  task automatic run_op(input string tag, input logic [1:0] fmt, input logic [7:0] cmd,
                        input logic [63:0] rs, input logic [63:0] rt,
                        input logic [63:0] exp_rs, input logic [63:0] exp_rt);
    drive(1'b1, fmt, cmd, rs, rt);
    step();
    drive(1'b0, 2'b00, 8'h00, 64'h0, 64'h0);
    step();
    check_val({tag, ".vld"}, 64'(outValid), 64'd1);
    check_val({tag, ".cmd"}, 64'(outOpCmd), 64'(cmd));
    check_val({tag, ".ixt"}, 64'(outIdIxt), 64'h15);
    check_val({tag, ".rs"}, outValRs, exp_rs);
    check_val({tag, ".rt"}, outValRt, exp_rt);
  endtask

  initial begin
    reset   = 1'b0;
    exHold  = 1'b0;
    exFlush = 1'b0;
    drive(1'b1, 2'b01, 8'h77, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
    step();
    step();
    check_val("rst.vld", 64'(outValid), 64'd0);
    check_val("rst.cmd", 64'(outOpCmd), 64'd0);
    check_val("rst.ixt", 64'(outIdIxt), 64'd0);
    check_val("rst.rs", outValRs, 64'd0);
    check_val("rst.rt", outValRt, 64'd0);
    drive(1'b0, 2'b00, 8'h00, 64'h0, 64'h0);
    reset = 1'b1;
    step();

    run_op("f32_one", 2'b01, 8'h11, 64'h3F80_0000, 64'hC000_0000,
           64'h3FF0_0000_0000_0000, 64'hC000_0000_0000_0000);
    run_op("f16_one_inf", 2'b10, 8'h12, 64'h3C00, 64'h7C00,
           64'h3FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000);
    run_op("f64_nan", 2'b00, 8'h13, 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000,
           64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000);
    run_op("f32_nan", 2'b01, 8'h14, 64'h7F80_0000, 64'hFF80_0001,
           64'h7FF0_0000_0000_0000, 64'hFFF8_0000_0000_0000);
    run_op("f32_ftz", 2'b01, 8'h15, 64'h8000_0001, 64'h3FC0_0000,
           64'h8000_0000_0000_0000, 64'h3FF8_0000_0000_0000);
    run_op("f64_ftz", 2'b00, 8'h16, 64'h8008_0000_0000_0000, 64'h0000_0000_0000_0001,
           64'h8000_0000_0000_0000, 64'h0);
    run_op("f16_misc", 2'b10, 8'h17, 64'hFFFF_FFFF_FFFF_8001, 64'h3E00,
           64'h8000_0000_0000_0000, 64'h3FF8_0000_0000_0000);
    run_op("f16_nan_hi", 2'b10, 8'h18, 64'hFE01, 64'h7BFF,
           64'hFFF8_0000_0000_0000, 64'h40EF_FC00_0000_0000);
    run_op("f32_upper", 2'b01, 8'h19, 64'hDEAD_BEEF_3F80_0000, 64'h0000_0001_0000_0000,
           64'h3FF0_0000_0000_0000, 64'h0);
    run_op("rsv_fmt", 2'b11, 8'h1A, 64'h4000_0000_0000_0000, 64'hFFF4_0000_0000_0000,
           64'h4000_0000_0000_0000, 64'hFFF8_0000_0000_0000);

    // Stream A, B, C with a three-cycle hold once B sits in stage 1
    drive(1'b1, 2'b00, 8'hA1, 64'h4000_0000_0000_0000, 64'h1);
    step();
    drive(1'b1, 2'b00, 8'hB2, 64'h4010_0000_0000_0000, 64'h2);
    step();
    check_val("strm.A.cmd", 64'(outOpCmd), 64'hA1);
    drive(1'b1, 2'b00, 8'hC3, 64'h4020_0000_0000_0000, 64'h3);
    exHold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("hold.vld", 64'(outValid), 64'd1);
      check_val("hold.cmd", 64'(outOpCmd), 64'hA1);
      check_val("hold.rs", outValRs, 64'h4000_0000_0000_0000);
    end
    exHold = 1'b0;
    step();
    check_val("strm.B.vld", 64'(outValid), 64'd1);
    check_val("strm.B.cmd", 64'(outOpCmd), 64'hB2);
    check_val("strm.B.rs", outValRs, 64'h4010_0000_0000_0000);
    drive(1'b0, 2'b00, 8'h00, 64'h0, 64'h0);
    step();
    check_val("strm.C.vld", 64'(outValid), 64'd1);
    check_val("strm.C.cmd", 64'(outOpCmd), 64'hC3);
    check_val("strm.C.rs", outValRs, 64'h4020_0000_0000_0000);
    step();
    check_val("strm.end.vld", 64'(outValid), 64'd0);

    // Flush with A in stage 2 and B in stage 1
    drive(1'b1, 2'b00, 8'hD1, 64'h4000_0000_0000_0000, 64'h0);
    step();
    drive(1'b1, 2'b00, 8'hD2, 64'h4010_0000_0000_0000, 64'h0);
    step();
    check_val("fl.pre.vld", 64'(outValid), 64'd1);
    drive(1'b1, 2'b00, 8'hD3, 64'h4020_0000_0000_0000, 64'h0);
    exFlush = 1'b1;
    step();
    check_val("fl.c1.vld", 64'(outValid), 64'd0);
    exFlush = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 64'h0, 64'h0);
    step();
    check_val("fl.c2.vld", 64'(outValid), 64'd0);

    // Flush together with hold: valids clear, data stays put
    drive(1'b1, 2'b00, 8'hE1, 64'h4000_0000_0000_0000, 64'h0);
    step();
    drive(1'b1, 2'b00, 8'hE2, 64'h4010_0000_0000_0000, 64'h0);
    step();
    exHold  = 1'b1;
    exFlush = 1'b1;
    step();
    check_val("flh.vld", 64'(outValid), 64'd0);
    check_val("flh.cmd", 64'(outOpCmd), 64'hE1);
    check_val("flh.rs", outValRs, 64'h4000_0000_0000_0000);
    exHold  = 1'b0;
    exFlush = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 64'h0, 64'h0);
    step();
    check_val("flh.next.vld", 64'(outValid), 64'd0);

    // Reset in the middle of a stream
    drive(1'b1, 2'b01, 8'hF1, 64'h3F80_0000, 64'h3F80_0000);
    step();
    drive(1'b1, 2'b01, 8'hF2, 64'h4000_0000, 64'h4000_0000);
    step();
    check_val("mrst.pre.vld", 64'(outValid), 64'd1);
    reset = 1'b0;
    step();
    check_val("mrst.vld", 64'(outValid), 64'd0);
    check_val("mrst.cmd", 64'(outOpCmd), 64'd0);
    check_val("mrst.ixt", 64'(outIdIxt), 64'd0);
    check_val("mrst.rs", outValRs, 64'd0);
    check_val("mrst.rt", outValRt, 64'd0);
    reset = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 64'h0, 64'h0);
    step();
    check_val("mrst.after.vld", 64'(outValid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
